// File: rtl/servant_uart_rx.sv
// 8N1 serial receiver: 2-flop synchroniser, mid-bit sampling FSM, one-deep valid/ready holding register.
// Byte valid HALF+9*CPB+1 cycles after the synchronised start edge; a byte completing while the register is full and unaccepted is dropped with o_overrun.
module servant_uart_rx #(
    parameter int CLK_FREQ_HZ = 32000000,
    parameter int BAUD_RATE   = 57600
) (
    input  logic       wb_clk,
    input  logic       wb_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);
    localparam int CPB  = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state;
    logic          sync_meta;
    logic          rxs;
    logic          first;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          complete;

    assign complete = (state == STOP) && (cnt == BIT_LAST) && rxs;
    assign o_busy   = (state != IDLE);

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync_meta   <= 1'b1;
            rxs         <= 1'b1;
            first       <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            sync_meta   <= i_rx;
            rxs         <= sync_meta;
            first       <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;

            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            // A completing byte may replace the old one only in the cycle it is accepted.
            if (complete) begin
                if (!o_valid || i_ready) begin
                    o_data  <= shreg;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        // A line already low straight out of reset must go high before it can start a frame.
                        state <= first ? BREAK : START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_servant_uart_rx.sv
// Bench for servant_uart_rx at CPB=16: directed frames plus random traffic against a sample-time model.
module tb_servant_uart_rx;
    localparam int CPB  = 16;
    localparam int HALF = 8;
    localparam int STOP_OFF = HALF + 9 * CPB;

    logic       wb_clk   = 1'b0;
    logic       wb_rst_n = 1'b1;
    logic       i_rx     = 1'b1;
    logic       i_ready  = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    servant_uart_rx #(.CLK_FREQ_HZ(1600), .BAUD_RATE(100)) dut (
        .wb_clk      (wb_clk),
        .wb_rst_n    (wb_rst_n),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: line value per cycle, frame decoded from absolute sample times.
    bit         hist [1024];
    logic       d1 = 1'b1, d2 = 1'b1;
    int         m_state = 0;
    bit         m_first = 1'b1;
    int         t0 = 0;
    logic       e_valid = 1'b0, e_ferr = 1'b0, e_ovr = 1'b0, e_busy = 1'b0;
    logic [7:0] e_data = 8'h00;

    always @(posedge wb_clk) begin
        logic       rxs;
        logic       done;
        logic       old_valid;
        logic [7:0] byt;
        int         off;
        cyc++;
        if (!wb_rst_n) begin
            d1 = 1'b1; d2 = 1'b1; m_state = 0; m_first = 1'b1;
            e_valid = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0; e_busy = 1'b0; e_data = 8'h00;
        end else begin
            rxs = d2; d2 = d1; d1 = i_rx;
            hist[cyc % 1024] = rxs;
            done = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0; byt = 8'h00;
            case (m_state)
                0: if (!rxs) begin
                       if (m_first) m_state = 2;
                       else begin m_state = 1; t0 = cyc; end
                   end
                1: begin
                       off = cyc - t0;
                       if (off == HALF && rxs) m_state = 0;
                       else if (off == STOP_OFF) begin
                           for (int i = 0; i < 8; i++)
                               byt[i] = hist[(t0 + HALF + (i + 1) * CPB) % 1024];
                           if (rxs) begin done = 1'b1; m_state = 0; end
                           else begin e_ferr = 1'b1; m_state = 2; end
                       end
                   end
                default: if (rxs) m_state = 0;
            endcase
            m_first = 1'b0;
            e_busy = (m_state != 0);
            old_valid = e_valid;
            if (old_valid && i_ready) e_valid = 1'b0;
            if (done) begin
                if (!old_valid || i_ready) begin e_data = byt; e_valid = 1'b1; end
                else e_ovr = 1'b1;
            end
        end
    end

    logic [7:0] got [$];
    int n_ferr = 0;
    int n_ovr  = 0;

    always @(negedge wb_clk) begin
        if (!wb_rst_n) begin
            check("rst_valid", int'(o_valid), 0);
            check("rst_data",  int'(o_data), 0);
            check("rst_ferr",  int'(o_frame_err), 0);
            check("rst_ovr",   int'(o_overrun), 0);
            check("rst_busy",  int'(o_busy), 0);
        end else begin
            check("valid", int'(o_valid), int'(e_valid));
            check("data",  int'(o_data), int'(e_data));
            check("ferr",  int'(o_frame_err), int'(e_ferr));
            check("ovr",   int'(o_overrun), int'(e_ovr));
            check("busy",  int'(o_busy), int'(e_busy));
            if (o_valid && i_ready) got.push_back(o_data);
            if (o_frame_err) n_ferr++;
            if (o_overrun) n_ovr++;
        end
    end

    bit rand_rdy = 1'b0;
    int start_edge = 0;
    int rise_edge = 0;

    task automatic tick();
        @(posedge wb_clk);
        #2;
        if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic hold(input logic v, input int n);
        i_rx = v;
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        start_edge = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop, CPB);
    endtask

    task automatic clear_mon();
        got.delete();
        n_ferr = 0;
        n_ovr  = 0;
    endtask

    task automatic check_got(input string nm, input logic [7:0] exp0, input logic [7:0] exp1,
                             input logic [7:0] exp2, input int n);
        logic [7:0] e [3];
        e[0] = exp0; e[1] = exp1; e[2] = exp2;
        check({nm, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            check({nm, "_byte"}, int'(got[i]), int'(e[i]));
    endtask

    initial begin
        #1 wb_rst_n = 1'b0;
        repeat (3) tick();
        wb_rst_n = 1'b1;
        hold(1'b1, 2 * CPB);

        // Single byte and its exact latency from the line edge.
        clear_mon();
        fork
            send(8'hA5, 1'b1);
            begin
                int n = 0;
                while (!o_valid && n < 400) begin
                    @(negedge wb_clk);
                    n++;
                end
                rise_edge = cyc;
                if (n >= 400) check("t1_valid_timeout", 0, 1);
            end
        join
        check("t1_latency", rise_edge - start_edge, 155);
        hold(1'b1, 3 * CPB);
        check_got("t1", 8'hA5, 8'h00, 8'h00, 1);
        check("t1_ferr", n_ferr, 0);
        check("t1_ovr", n_ovr, 0);

        // Back-to-back frames.
        clear_mon();
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        hold(1'b1, 3 * CPB);
        check_got("t2", 8'h00, 8'hFF, 8'h55, 3);
        check("t2_ferr", n_ferr, 0);

        // Short glitch is rejected.
        clear_mon();
        hold(1'b0, 5);
        hold(1'b1, 3 * CPB);
        check("t3_count", got.size(), 0);
        check("t3_ferr", n_ferr, 0);
        check("t3_busy", int'(o_busy), 0);

        // Low stop bit followed by a long break, then a good byte.
        clear_mon();
        send(8'h3C, 1'b0);
        hold(1'b0, 40 * CPB);
        check("t4_busy_in_break", int'(o_busy), 1);
        hold(1'b1, 2 * CPB);
        check("t4_ferr", n_ferr, 1);
        check("t4_count", got.size(), 0);
        send(8'h12, 1'b1);
        hold(1'b1, 3 * CPB);
        check_got("t4", 8'h12, 8'h00, 8'h00, 1);
        check("t4_ferr_after", n_ferr, 1);

        // Consumer stalled: second byte dropped with one overrun.
        clear_mon();
        i_ready = 1'b0;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        hold(1'b1, 3 * CPB);
        check("t5_ovr", n_ovr, 1);
        check("t5_valid_held", int'(o_valid), 1);
        check("t5_data_held", int'(o_data), 8'h11);
        i_ready = 1'b1;
        hold(1'b1, 2 * CPB);
        check_got("t5", 8'h11, 8'h00, 8'h00, 1);
        check("t5_valid_after", int'(o_valid), 0);

        // Reset during data bit 3 of 0x7E, then a clean frame.
        clear_mon();
        hold(1'b0, CPB);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b1, CPB);
        hold(1'b1, HALF);
        check("t6_busy_mid", int'(o_busy), 1);
        wb_rst_n = 1'b0;
        hold(1'b1, 3);
        wb_rst_n = 1'b1;
        hold(1'b1, 3 * CPB);
        check("t6_busy_after", int'(o_busy), 0);
        check("t6_valid_after", int'(o_valid), 0);
        send(8'h81, 1'b1);
        hold(1'b1, 3 * CPB);
        check_got("t6", 8'h81, 8'h00, 8'h00, 1);
        check("t6_ferr", n_ferr, 0);

        // Random traffic with random consumer stalls, checked cycle by cycle against the model.
        clear_mon();
        rand_rdy = 1'b1;
        for (int k = 0; k < 30; k++) begin
            int kind;
            kind = $urandom_range(0, 7);
            if (kind < 6) send(8'($urandom_range(0, 255)), 1'b1);
            else if (kind == 6) hold(1'b0, $urandom_range(1, 6));
            else begin
                send(8'($urandom_range(0, 255)), 1'b0);
                hold(1'b0, $urandom_range(0, 3 * CPB));
            end
            hold(1'b1, $urandom_range(1, 20));
        end
        rand_rdy = 1'b0;
        i_ready = 1'b1;
        hold(1'b1, 4 * CPB);
        check("rand_idle_busy", int'(o_busy), 0);
        check("rand_idle_valid", int'(o_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
